product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Downstream consumer of the 4x4 multiplier's 8-bit product bus.
//   Sums a burst of products (BURST products, or fewer if in_last ends it early) into a wide accumulator.
//   Presents each finished sum on a valid/ready output port and holds it there until it is taken.
//   Provides the clocked, flow-controlled stage that turns the combinational product into dot-product-style results.
// PARAMETERS
//   PROD_W    8   width of incoming product (4x4 multiplier output)
//   ACC_W     12  accumulator / out_sum width; must be >= PROD_W
//   BURST     4   products per sum, 1..15
//   SATURATE  1   1: clamp at 2^ACC_W-1; 0: wrap modulo 2^ACC_W
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   clear      in   1       synchronous flush; drops partial burst and pending output
//   in_valid   in   1       in_prod valid
//   in_ready   out  1       block accepts in_prod this cycle
//   in_prod    in   PROD_W  product from multiplier
//   in_last    in   1       qualifies the accepted product as the final one of its burst
//   out_valid  out  1       out_sum/out_count/out_ovf valid
//   out_ready  in   1       consumer takes the result
//   out_sum    out  ACC_W   burst sum
//   out_count  out  4       number of products in the burst (1..BURST)
//   out_ovf    out  1       sticky: an add in this burst exceeded 2^ACC_W-1
// BEHAVIOUR
//   - Reset (async, active-high): state=ACCUM; acc, cnt, ovf, out_sum, out_count, out_ovf, out_valid = 0.
//     in_ready is a registered output: 0 while rst is asserted, 1 from the first clk edge after release.
//   - Accept: in_valid && in_ready at a rising edge. Gaps in in_valid are allowed; state is held across them.
//   - ACCUM (in_ready=1, out_valid=0), on each accept:
//       sum   = acc + in_prod, computed at ACC_W+1 bits
//       carry = sum[ACC_W]
//       acc   <= carry ? (SATURATE ? all-ones : sum[ACC_W-1:0]) : sum
//       ovf   <= ovf | carry
//       cnt   <= cnt + 1
//   - Burst end: cnt+1 == BURST or in_last. At that same edge:
//       out_sum/out_count/out_ovf <= new acc/cnt/ovf values
//       acc, cnt, ovf <= 0
//       out_valid <= 1, in_ready <= 0, state -> HOLD
//     out_valid rises in the cycle after the last accept.
//   - HOLD (in_ready=0, out_valid=1):
//       out_* are stable while out_ready=0.
//       Edge with out_ready=1: out_valid <= 0, in_ready <= 1, state -> ACCUM.
//     Costs exactly one bubble cycle per burst when out_ready is held 1.
//   - in_prod is ignored when not accepted; products offered during HOLD are not consumed (producer holds them).
//   - clear (sync), priority below rst and above all else:
//       acc, cnt, ovf = 0; out_valid = 0; in_ready = 1; state = ACCUM.
//       out_sum is not zeroed. A simultaneous accept is discarded.
//   - rst mid-burst or in HOLD: outputs drop to their reset values immediately (async); no result is emitted.
//   - in_last on the BURST-th product: a single burst end (no double emit).
//   - Illegal state encodings recover to ACCUM.
// STRUCTURE
//   - Package mult_pkg holds:
//       localparams PROD_W=8, ACC_W_DEF=12
//       enum acc_state_t {ACCUM, HOLD}
//       function sat_add (shared with future MAC stages)
//   - One sub-module: sat_adder
//       #(IN_W, ACC_W, SATURATE), purely combinational
//       outputs sum and carry
//   - FSM, counters and output register are in this file.
// TESTING
//   1 Reset: rst=1 for 3 cycles -> out_valid=0, out_sum=0, in_ready=0; one edge after release, in_ready=1.
//   2 Burst of 1,16,45,225 (1x1, 2x8, 15x3, 15x15) back-to-back -> cycle after 4th accept:
//     out_valid=1, out_sum=287, out_count=4, out_ovf=0.
//   3 Products 45 then 225 with in_last on the second -> out_sum=270, out_count=2; next burst starts from 0.
//   4 Backpressure: out_ready=0 for 5 cycles with in_valid=1 and in_prod=9 ->
//     in_ready=0, out_sum stable for all 5 cycles; after out_ready=1 the 9 is accepted as product 1 of the next burst.
//   5 ACC_W=10, BURST=5, five products of 225:
//     SATURATE=1 -> out_sum=1023, out_ovf=1; SATURATE=0 -> out_sum=101, out_ovf=1.
//   6 clear after 2 accepted products, then four products of 1 -> out_sum=4, out_count=4.
//     rst pulse in HOLD -> out_valid=0 within the same cycle; no result delivered.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiplier datapath and its downstream
// accumulation stages.
package mult_pkg;

   localparam int PROD_W    = 8;
   localparam int ACC_W_DEF = 12;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   // Generic add with carry-out for widths up to 32 bits.
   // Returns {carry, result}; result clamps to all-ones when sat is set.
   function automatic logic [32:0] sat_add(
      input logic [31:0] a,
      input logic [31:0] b,
      input int unsigned w,
      input logic        sat
   );
      logic [32:0] s;
      logic [31:0] mask;
      logic        c;
      mask = (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      s    = {1'b0, a} + {1'b0, b};
      c    = (w >= 32'd32) ? s[32] : (|(s[31:0] & ~mask));
      if (c && sat) begin
         return {1'b1, mask};
      end else begin
         return {c, s[31:0] & mask};
      end
   endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational accumulator adder: adds a narrow product into an ACC_W-bit
// value, reporting the carry and optionally clamping on overflow.
module sat_adder
   import mult_pkg::*;
#(
   parameter int IN_W     = 8,
   parameter int ACC_W    = 12,
   parameter int SATURATE = 1
) (
   input  logic [ACC_W-1:0] i_acc,
   input  logic [IN_W-1:0]  i_add,
   output logic [ACC_W-1:0] o_sum,
   output logic             o_carry
);

   logic [ACC_W:0] w_sum;

   assign w_sum   = {1'b0, i_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, i_add};
   assign o_carry = w_sum[ACC_W];

   // Clamp or wrap the result depending on the overflow policy.
   always_comb begin
      if (w_sum[ACC_W] && (SATURATE != 0)) begin
         o_sum = {ACC_W{1'b1}};
      end else begin
         o_sum = w_sum[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/product_accumulator.sv
// Sums bursts of multiplier products and presents each finished sum on a
// valid/ready port, holding it until the consumer takes it.
module product_accumulator #(
   parameter int PROD_W   = mult_pkg::PROD_W,
   parameter int ACC_W    = mult_pkg::ACC_W_DEF,
   parameter int BURST    = 4,
   parameter int SATURATE = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [PROD_W-1:0] i_in_prod,
   input  logic              i_in_last,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [ACC_W-1:0]  o_out_sum,
   output logic [3:0]        o_out_count,
   output logic              o_out_ovf
);

   import mult_pkg::*;

   acc_state_t       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [3:0]       r_cnt;
   logic             r_ovf;
   logic [ACC_W-1:0] r_out_sum;
   logic [3:0]       r_out_count;
   logic             r_out_ovf;
   logic             r_out_valid;
   logic             r_in_ready;

   logic [ACC_W-1:0] w_sum;
   logic             w_carry;
   logic             w_accept;
   logic [3:0]       w_cnt_nxt;
   logic             w_end;

   sat_adder #(
      .IN_W     (PROD_W),
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
   ) u_sat_adder (
      .i_acc   (r_acc),
      .i_add   (i_in_prod),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign w_accept  = i_in_valid && r_in_ready && (r_state == ACCUM);
   assign w_cnt_nxt = r_cnt + 4'd1;
   // in_last on the BURST-th product still yields a single burst end.
   assign w_end     = (w_cnt_nxt == 4'(BURST)) || i_in_last;

   // Burst FSM, accumulator, counters and registered output port.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ACCUM;
         r_acc       <= '0;
         r_cnt       <= 4'd0;
         r_ovf       <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= 4'd0;
         r_out_ovf   <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
      end else if (i_clear) begin
         r_state     <= ACCUM;
         r_acc       <= '0;
         r_cnt       <= 4'd0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            ACCUM: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               if (w_accept) begin
                  if (w_end) begin
                     r_out_sum   <= w_sum;
                     r_out_count <= w_cnt_nxt;
                     r_out_ovf   <= r_ovf | w_carry;
                     r_acc       <= '0;
                     r_cnt       <= 4'd0;
                     r_ovf       <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_in_ready  <= 1'b0;
                     r_state     <= HOLD;
                  end else begin
                     r_acc <= w_sum;
                     r_cnt <= w_cnt_nxt;
                     r_ovf <= r_ovf | w_carry;
                  end
               end
            end
            HOLD: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ACCUM;
               end
            end
            default: begin
               r_state     <= ACCUM;
               r_acc       <= '0;
               r_cnt       <= 4'd0;
               r_ovf       <= 1'b0;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_sum   = r_out_sum;
   assign o_out_count = r_out_count;
   assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance plus two
// ACC_W=10/BURST=5 instances exercising saturate and wrap policies.
module tb_product_accumulator;

   logic        clk = 1'b0;
   logic        rst, clear;
   logic        in_valid, in_last, out_ready;
   logic [7:0]  in_prod;
   logic        in_ready, out_valid, out_ovf;
   logic [11:0] out_sum;
   logic [3:0]  out_count;

   logic        b_valid, b_last, b_out_ready;
   logic [7:0]  b_prod;
   logic        s_in_ready, s_out_valid, s_out_ovf;
   logic [9:0]  s_out_sum;
   logic [3:0]  s_out_count;
   logic        w_in_ready, w_out_valid, w_out_ovf;
   logic [9:0]  w_out_sum;
   logic [3:0]  w_out_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   product_accumulator dut (
      .i_clk(clk), .i_rst(rst), .i_clear(clear),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_prod(in_prod),
      .i_in_last(in_last), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_sum(out_sum), .o_out_count(out_count), .o_out_ovf(out_ovf)
   );

   product_accumulator #(.PROD_W(8), .ACC_W(10), .BURST(5), .SATURATE(1)) dut_s (
      .i_clk(clk), .i_rst(rst), .i_clear(clear),
      .i_in_valid(b_valid), .o_in_ready(s_in_ready), .i_in_prod(b_prod),
      .i_in_last(b_last), .o_out_valid(s_out_valid), .i_out_ready(b_out_ready),
      .o_out_sum(s_out_sum), .o_out_count(s_out_count), .o_out_ovf(s_out_ovf)
   );

   product_accumulator #(.PROD_W(8), .ACC_W(10), .BURST(5), .SATURATE(0)) dut_w (
      .i_clk(clk), .i_rst(rst), .i_clear(clear),
      .i_in_valid(b_valid), .o_in_ready(w_in_ready), .i_in_prod(b_prod),
      .i_in_last(b_last), .o_out_valid(w_out_valid), .i_out_ready(b_out_ready),
      .o_out_sum(w_out_sum), .o_out_count(w_out_count), .o_out_ovf(w_out_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] p, input logic last);
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0;
      in_valid = 1'b0; in_last = 1'b0; in_prod = 8'd0; out_ready = 1'b1;
      b_valid = 1'b0; b_last = 1'b0; b_prod = 8'd0; b_out_ready = 1'b1;

      // 1: reset
      repeat (3) step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      rst = 1'b0;
      step();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // 2: full burst back-to-back
      send(8'd1, 1'b0); send(8'd16, 1'b0); send(8'd45, 1'b0); send(8'd225, 1'b0);
      check("b2_out_valid", 32'(out_valid), 32'd1);
      check("b2_out_sum",   32'(out_sum),   32'd287);
      check("b2_out_count", 32'(out_count), 32'd4);
      check("b2_out_ovf",   32'(out_ovf),   32'd0);
      check("b2_in_ready",  32'(in_ready),  32'd0);
      step();
      check("b2_release_valid", 32'(out_valid), 32'd0);
      check("b2_release_ready", 32'(in_ready),  32'd1);

      // 3: early end with in_last
      send(8'd45, 1'b0); send(8'd225, 1'b1);
      check("b3_out_valid", 32'(out_valid), 32'd1);
      check("b3_out_sum",   32'(out_sum),   32'd270);
      check("b3_out_count", 32'(out_count), 32'd2);
      step();

      // 4: backpressure; fresh burst starts from zero
      out_ready = 1'b0;
      send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
      check("b4_out_sum", 32'(out_sum), 32'd100);
      in_valid = 1'b1; in_prod = 8'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_sum",   32'(out_sum),   32'd100);
      end
      out_ready = 1'b1;
      step();
      check("bp_release_ready", 32'(in_ready),  32'd1);
      check("bp_release_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_sum",   32'(out_sum),   32'd12);
      check("bp_next_count", 32'(out_count), 32'd4);
      step();

      // 5: ACC_W=10, BURST=5 overflow policies
      b_valid = 1'b1; b_prod = 8'd225;
      repeat (5) step();
      b_valid = 1'b0;
      check("sat_out_valid", 32'(s_out_valid), 32'd1);
      check("sat_out_sum",   32'(s_out_sum),   32'd1023);
      check("sat_out_ovf",   32'(s_out_ovf),   32'd1);
      check("sat_out_count", 32'(s_out_count), 32'd5);
      check("wrap_out_valid", 32'(w_out_valid), 32'd1);
      check("wrap_out_sum",   32'(w_out_sum),   32'd101);
      check("wrap_out_ovf",   32'(w_out_ovf),   32'd1);
      step();

      // 6: clear drops partial burst and discards simultaneous accept
      send(8'd5, 1'b0); send(8'd6, 1'b0);
      clear = 1'b1; in_valid = 1'b1; in_prod = 8'd7;
      step();
      clear = 1'b0; in_valid = 1'b0;
      check("clr_in_ready",  32'(in_ready),  32'd1);
      check("clr_out_valid", 32'(out_valid), 32'd0);
      send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b1);
      check("clr_out_valid2", 32'(out_valid), 32'd1);
      check("clr_out_sum",    32'(out_sum),   32'd4);
      check("clr_out_count",  32'(out_count), 32'd4);
      step();
      step();
      check("no_double_emit", 32'(out_valid), 32'd0);

      // rst pulse while holding a result
      out_ready = 1'b0;
      send(8'd2, 1'b0); send(8'd2, 1'b0); send(8'd2, 1'b0); send(8'd2, 1'b0);
      check("hold_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_ready", 32'(in_ready),  32'd0);
      check("async_rst_sum",   32'(out_sum),   32'd0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check("post_rst_no_result", 32'(out_valid), 32'd0);
      check("post_rst_ready",     32'(in_ready),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
